// File: rtl/axi_burst_master_if.sv
// Command, AXI4 and read-stream signals of axi_burst_master, bundled as one interface.
// master: the burst master's view. slave: the view of whatever drives commands and
// responds on the AXI channels.
interface axi_burst_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
);
    // Command port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [LEN_W-1:0]      cmd_len;
    logic [1:0]            cmd_burst;
    logic [DATA_W-1:0]     cmd_wbase;
    // AXI read address / data
    logic [ADDR_W-1:0]     araddr;
    logic [LEN_W-1:0]      arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    // AXI write address / data / response
    logic [ADDR_W-1:0]     awaddr;
    logic [LEN_W-1:0]      awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // Read beat stream and completion status
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  done;
    logic                  err;
    logic                  len_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_burst, cmd_wbase,
        output cmd_ready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output rd_data, rd_valid, rd_last, done, err, len_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_burst, cmd_wbase,
        input  cmd_ready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  rd_data, rd_valid, rd_last, done, err, len_err
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master. Accepts one command, runs a read or write
// burst, streams read beats out unbuffered and pulses done with err/len_err status.
// Write data is a counting pattern: cmd_wbase + beat index.
module axi_burst_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,  // 32, 64 or 128
    parameter int unsigned LEN_W  = 8
) (
    input logic             aclk,
    input logic             areset_n,
    axi_burst_master_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SIZE   = $clog2(STRB_W);

    typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWaddr, StWdata, StWresp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [1:0]        burst_q;
    logic [DATA_W-1:0] wbase_q;
    logic              err_q;
    logic              wrap_err_q;  // illegal WRAP accepted last cycle: report it now

    logic cmd_hs, r_hs, w_hs, b_hs, bad_wrap;

    // Handshake decode; inputs only count in the state that owns them
    always_comb begin
        cmd_hs   = bus.cmd_valid && (state_q == StIdle);
        r_hs     = bus.rvalid && (state_q == StRdata);
        w_hs     = bus.wready && (state_q == StWdata);
        b_hs     = bus.bvalid && (state_q == StWresp);
        // WRAP bursts must be 2, 4, 8 or 16 beats long
        bad_wrap = (bus.cmd_burst == 2'b10) &&
                   (bus.cmd_len != LEN_W'(1)) && (bus.cmd_len != LEN_W'(3)) &&
                   (bus.cmd_len != LEN_W'(7)) && (bus.cmd_len != LEN_W'(15));
    end

    // Next state and all bus outputs
    always_comb begin
        state_d     = state_q;
        bus.cmd_ready = (state_q == StIdle);
        bus.araddr  = '0;
        bus.arlen   = len_q;
        bus.arsize  = 3'(SIZE);
        bus.arburst = burst_q;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awaddr  = '0;
        bus.awlen   = len_q;
        bus.awsize  = 3'(SIZE);
        bus.awburst = burst_q;
        bus.awvalid = 1'b0;
        bus.wdata   = wbase_q + DATA_W'(cnt_q);
        bus.wstrb   = '1;
        bus.wlast   = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.rd_data = bus.rdata;
        bus.rd_valid = r_hs;
        bus.rd_last = r_hs && bus.rlast;
        bus.done    = wrap_err_q || (r_hs && bus.rlast) || b_hs;
        bus.err     = err_q || (r_hs && (bus.rresp != 2'b00)) || (b_hs && (bus.bresp != 2'b00));
        bus.len_err = r_hs && bus.rlast && (cnt_q != len_q);

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && !bad_wrap) state_d = bus.cmd_write ? StWaddr : StRaddr;
            end
            StRaddr: begin
                bus.arvalid = 1'b1;
                bus.araddr  = addr_q;
                if (bus.arready) state_d = StRdata;
            end
            StRdata: begin
                bus.rready = 1'b1;
                if (bus.rvalid && bus.rlast) state_d = StIdle;
            end
            StWaddr: begin
                bus.awvalid = 1'b1;
                bus.awaddr  = addr_q;
                if (bus.awready) state_d = StWdata;
            end
            StWdata: begin
                bus.wvalid = 1'b1;
                bus.wlast  = (cnt_q == len_q);
                if (bus.wready && (cnt_q == len_q)) state_d = StWresp;
            end
            StWresp: begin
                bus.bready = 1'b1;
                if (bus.bvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched command and beat/error bookkeeping
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            burst_q    <= '0;
            wbase_q    <= '0;
            err_q      <= 1'b0;
            wrap_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrap_err_q <= cmd_hs && bad_wrap;
            if (cmd_hs) begin
                addr_q  <= bus.cmd_addr & ~ADDR_W'(STRB_W - 1);
                len_q   <= bus.cmd_len;
                burst_q <= bus.cmd_burst;
                wbase_q <= bus.cmd_wbase;
                cnt_q   <= '0;
                err_q   <= bad_wrap;
            end else begin
                // Saturate rather than wrap so an overlong read still reports len_err sanely
                if ((r_hs || w_hs) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
                if ((r_hs && (bus.rresp != 2'b00)) || (b_hs && (bus.bresp != 2'b00))) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule
